fpm_rr_sched: RTL
=================

Name: fpm_rr_sched

Overview:
- Round-robin scheduler that shares one floating-point multiplier (fp_X, fp_Y, r_mode in; fp_Z, ovrf, udrf out) among N_REQ requesters.
- Each requester uses a valid/ready handshake. The block registers the winning operands into the multiplier and tracks the requester ID through a delay line matched to the multiplier latency.
- It returns the result, flags and ID as a one-cycle response pulse.
- It sits between the testbench/agents or upstream units and the FP multiplier DUT.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 1, multiplier latency in cycles from operands presented to fp_Z valid (0 = combinational, 0..8).
- ID_W, 2, width of requester ID; must be at least ceil(log2(N_REQ)).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester grant; at most one bit high.
- req_x  in  32*N_REQ  X operands; requester i in bits [32i+31:32i].
- req_y  in  32*N_REQ  Y operands, same packing.
- req_rmode  in  3*N_REQ  rounding modes; requester i in [3i+2:3i].
- mul_x  out  32  fp_X to multiplier.
- mul_y  out  32  fp_Y to multiplier.
- mul_rmode  out  3  r_mode to multiplier.
- mul_valid  out  1  mul_x/mul_y/mul_rmode carry a new operation this cycle.
- mul_z  in  32  fp_Z from multiplier.
- mul_ovrf  in  1  overflow flag from multiplier.
- mul_udrf  in  1  underflow flag from multiplier.
- rsp_valid  out  1  response pulse.
- rsp_id  out  ID_W  requester that owns the response.
- rsp_z  out  32  product.
- rsp_ovrf  out  1  overflow flag.
- rsp_udrf  out  1  underflow flag.
- busy  out  1  at least one operation in flight.

Behaviour:

Reset (rst=1 at posedge):
- ptr=0, mul_x=0, mul_y=0, mul_rmode=0, mul_valid=0.
- Tag pipe cleared: all valid bits 0.
- rsp_valid=0, rsp_id=0, rsp_z=0, rsp_ovrf=0, rsp_udrf=0, busy=0.
- While rst=1, req_ready is forced to 0.

Arbitration (combinational):
- Search req_valid starting at index ptr, ascending with wrap modulo N_REQ.
- The first set bit i is the winner: req_ready[i]=1, all other bits 0.
- No valid requester: req_ready=0.
- The scheduler never stalls; one grant is possible every cycle.

Issue (registered at posedge):
- On a handshake (req_valid[i] & req_ready[i]):
  - mul_x, mul_y, mul_rmode take requester i's fields.
  - mul_valid=1.
  - ptr=(i+1) mod N_REQ.
  - Stage 0 of the tag pipe gets {valid=1, id=i}.
- Without a handshake:
  - mul_valid=0 and mul_x/mul_y/mul_rmode hold their last values.
  - ptr unchanged.
  - Stage 0 valid=0.

Tag pipe and response:
- The tag pipe has MUL_LAT stages, shifted every cycle.
- The tag leaving the last stage (stage 0 directly when MUL_LAT=0) is aligned with mul_z.
- At that point, register rsp_valid=tag.valid, rsp_id=tag.id, rsp_z=mul_z, rsp_ovrf=mul_ovrf, rsp_udrf=mul_udrf.
- When tag.valid=0, rsp_z/rsp_id/flags hold their previous values.
- Latency: handshake at posedge k gives rsp_valid high for exactly the cycle following posedge k+1+MUL_LAT.
- Fully pipelined: back-to-back grants give back-to-back responses in grant order.
- No response backpressure; consumers must accept every pulse.

busy:
- Registered; equals the OR of mul_valid and all tag-pipe valid bits after the update.
- busy=0 implies no rsp_valid will follow until a new handshake.

Boundary conditions:
- All requesters valid: strict rotation ptr, ptr+1, ... with wrap from N_REQ-1 to 0.
- Single continuous requester: granted every cycle.
- A requester dropping req_valid without a grant is legal; no state changes.
- Reset mid-flight: all in-flight tags are discarded and no rsp_valid is produced for operations accepted before reset.

Test Plan:
1. Single request, MUL_LAT=1: reset, then only requester 2 presents X=0x3F800000, Y=0x40000000, rmode=0 for one cycle -> req_ready=4'b0100 that cycle; mul_valid next cycle; rsp_valid=1, rsp_id=2, rsp_z=0x40000000, flags 0, exactly 2 cycles after the handshake edge; busy falls afterwards.
2. Full contention: all 4 requesters valid continuously from reset, each with distinct X (1.0, 2.0, 3.0, 4.0) and Y=2.0 -> grants 0,1,2,3,0,... one per cycle; responses back-to-back with ids 0,1,2,3 and z=0x40000000, 0x40800000, 0x40C00000, 0x41000000.
3. Fairness: requester 0 always valid, requester 3 valid starting cycle 5 -> grants alternate 3,0,3,0; neither requester waits more than 1 cycle.
4. Flag pass-through: X=Y=0x7F000000 from requester 1 -> rsp_ovrf=1, rsp_udrf=0, rsp_id=1; X=Y=0x00800000 -> rsp_udrf=1.
5. Reset mid-flight, MUL_LAT=3: issue 2 operations, assert rst on the next edge -> no rsp_valid for them, busy=0, ptr=0 (next all-valid grant goes to 0).
6. Idle: no req_valid for 10 cycles after traffic -> mul_valid=0, mul_x/mul_y held, rsp_valid=0, ptr unchanged.

Source files
------------

// File: rtl/fpm_rr_sched_if.sv
// fpm_rr_sched_if
// Bundles the signals between the round-robin scheduler, its requesters and
// the shared floating-point multiplier.
//   req_valid/req_ready : per-requester handshake (ready is the grant)
//   req_x/req_y         : packed 32-bit operands, requester i at [32i+31:32i]
//   req_rmode           : packed 3-bit rounding modes, requester i at [3i+2:3i]
//   mul_x/mul_y/mul_rmode/mul_valid : registered operands to the multiplier
//   mul_z/mul_ovrf/mul_udrf         : multiplier result and flags
//   rsp_valid/rsp_id/rsp_z/rsp_ovrf/rsp_udrf : one-cycle response pulse
//   busy                : at least one operation in flight
// Modports: slave = scheduler side, master = requesters plus multiplier side.
interface fpm_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [32*N_REQ-1:0] req_x;
  logic [32*N_REQ-1:0] req_y;
  logic [3*N_REQ-1:0] req_rmode;
  logic [31:0]        mul_x;
  logic [31:0]        mul_y;
  logic [2:0]         mul_rmode;
  logic               mul_valid;
  logic [31:0]        mul_z;
  logic               mul_ovrf;
  logic               mul_udrf;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        rsp_z;
  logic               rsp_ovrf;
  logic               rsp_udrf;
  logic               busy;

  modport slave (
    input  req_valid, req_x, req_y, req_rmode, mul_z, mul_ovrf, mul_udrf,
    output req_ready, mul_x, mul_y, mul_rmode, mul_valid,
           rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, busy
  );

  modport master (
    output req_valid, req_x, req_y, req_rmode, mul_z, mul_ovrf, mul_udrf,
    input  req_ready, mul_x, mul_y, mul_rmode, mul_valid,
           rsp_valid, rsp_id, rsp_z, rsp_ovrf, rsp_udrf, busy
  );
endinterface

// File: rtl/fpm_rr_sched.sv
// fpm_rr_sched
// Round-robin scheduler sharing one floating-point multiplier among N_REQ
// requesters. One grant per cycle, fully pipelined; the requester ID travels
// through a tag pipe matched to the multiplier latency and comes back with
// the product as a one-cycle response pulse.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : fpm_rr_sched_if.slave (requests, multiplier link, response, busy)
module fpm_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic           clk,
  input  logic           rst,
  fpm_rr_sched_if.slave  bus
);

  logic [ID_W-1:0]  ptr;
  logic             found;
  int               win_idx;
  logic [N_REQ-1:0] grant;
  logic             hs;
  logic             busy_next;

  // Stage 0 is loaded together with mul_x/mul_y, so it lines up with the
  // operands; MUL_LAT further stages line the tag up with mul_z.
  logic [MUL_LAT:0] tag_v;
  logic [ID_W-1:0]  tag_id [MUL_LAT+1];

  // Rotating priority search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[(int'(ptr) + k) % N_REQ]) begin
        found   = 1'b1;
        win_idx = (int'(ptr) + k) % N_REQ;
      end
    end
  end

  // Grants are suppressed during reset so nothing is accepted then.
  always_comb begin
    grant = '0;
    if (found && !rst) grant[win_idx] = 1'b1;
  end

  assign hs            = found & ~rst;
  assign bus.req_ready = grant;

  // busy reflects the state after this edge: the new issue plus every tag
  // that is still inside the pipe once it has shifted.
  always_comb begin
    busy_next = hs;
    for (int s = 0; s < MUL_LAT; s++) busy_next = busy_next | tag_v[s];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      bus.mul_x     <= '0;
      bus.mul_y     <= '0;
      bus.mul_rmode <= '0;
      bus.mul_valid <= 1'b0;
      tag_v         <= '0;
      for (int s = 0; s <= MUL_LAT; s++) tag_id[s] <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_z     <= '0;
      bus.rsp_ovrf  <= 1'b0;
      bus.rsp_udrf  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.mul_valid <= hs;
      tag_v[0]      <= hs;
      // Operands hold their last values when nothing is issued.
      if (hs) begin
        bus.mul_x     <= bus.req_x[32*win_idx +: 32];
        bus.mul_y     <= bus.req_y[32*win_idx +: 32];
        bus.mul_rmode <= bus.req_rmode[3*win_idx +: 3];
        ptr           <= ID_W'((win_idx + 1) % N_REQ);
        tag_id[0]     <= ID_W'(win_idx);
      end
      for (int s = 1; s <= MUL_LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      // The tag leaving the last stage is aligned with mul_z.
      bus.rsp_valid <= tag_v[MUL_LAT];
      if (tag_v[MUL_LAT]) begin
        bus.rsp_id   <= tag_id[MUL_LAT];
        bus.rsp_z    <= bus.mul_z;
        bus.rsp_ovrf <= bus.mul_ovrf;
        bus.rsp_udrf <= bus.mul_udrf;
      end
      bus.busy <= busy_next;
    end
  end

endmodule
